// File: rtl/alu_pkg.sv
// Shared opcodes, handshake FSM states and flag bundle for alu_multicycle.
// ALU_DIV_EN selects whether DIV/REM are sequenced opcodes or illegal ones.
package alu_pkg;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SUB  = 4'b0011;
    localparam logic [3:0] ALU_SLT  = 4'b0100;
    localparam logic [3:0] ALU_XOR  = 4'b0101;
    localparam logic [3:0] ALU_MULT = 4'b0111;
    localparam logic [3:0] ALU_DIV  = 4'b1000;
    localparam logic [3:0] ALU_REM  = 4'b1001;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } alu_state_e;

    typedef struct packed {
        logic zero;
        logic carry;
        logic ovf;
        logic err;
    } alu_flags_t;

    // Opcodes that go through the iterative engine (divide-by-zero is filtered by the caller).
    function automatic logic op_is_seq(input logic [3:0] op);
`ifdef ALU_DIV_EN
        return (op == ALU_MULT) || (op == ALU_DIV) || (op == ALU_REM);
`else
        return (op == ALU_MULT);
`endif
    endfunction

endpackage

// File: rtl/alu_seq_muldiv.sv
// Iterative engine: shift-add multiply (LSB first), restoring divide when ALU_DIV_EN is defined.
// WIDTH iterations after start; done_o flags the last one and lo_o/hi_o carry its result.
// No backpressure: the caller must capture the result in the cycle done_o is high.
module alu_seq_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             div_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             done_o,
    output logic [WIDTH-1:0] lo_o,
    output logic [WIDTH-1:0] hi_o
);

    localparam int CW = $clog2(WIDTH) + 1;

    logic             busy_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] hi_d;
    logic [WIDTH-1:0] lo_d;
    logic [WIDTH:0]   mul_sum;

`ifdef ALU_DIV_EN
    logic             div_q;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   rem_diff;
`else
    logic             unused_div;
    assign unused_div = div_i;
`endif

    // Multiply: {hi,lo} holds {partial product, remaining multiplier bits}.
    // Divide:   hi is the partial remainder, lo shifts dividend out and quotient in.
    always_comb begin
        mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : {(WIDTH+1){1'b0}});
        hi_d    = mul_sum[WIDTH:1];
        lo_d    = {mul_sum[0], lo_q[WIDTH-1:1]};
`ifdef ALU_DIV_EN
        rem_sh   = {hi_q, lo_q[WIDTH-1]};
        rem_diff = rem_sh - {1'b0, b_q};
        if (div_q) begin
            if (rem_diff[WIDTH]) begin
                hi_d = rem_sh[WIDTH-1:0];
                lo_d = {lo_q[WIDTH-2:0], 1'b0};
            end else begin
                hi_d = rem_diff[WIDTH-1:0];
                lo_d = {lo_q[WIDTH-2:0], 1'b1};
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            b_q    <= '0;
`ifdef ALU_DIV_EN
            div_q  <= 1'b0;
`endif
        end else if (start_i) begin
            busy_q <= 1'b1;
            cnt_q  <= '0;
            hi_q   <= '0;
            lo_q   <= a_i;
            b_q    <= b_i;
`ifdef ALU_DIV_EN
            div_q  <= div_i;
`endif
        end else if (busy_q) begin
            hi_q  <= hi_d;
            lo_q  <= lo_d;
            cnt_q <= cnt_q + 1'b1;
            if (done_o) begin
                busy_q <= 1'b0;
            end
        end
    end

    assign done_o = busy_q && (cnt_q == CW'(WIDTH - 1));
    assign lo_o   = lo_d;
    assign hi_o   = hi_d;

endmodule

// File: rtl/alu_multicycle.sv
// Multicycle ALU with valid/ready on both sides; MULT (and DIV/REM with ALU_DIV_EN) iterate in BUSY.
// Latency 1 for single-cycle ops, WIDTH+1 for iterative ops; one op in flight at a time.
// Result is held in DONE until out_ready; in_ready is low outside IDLE.
module alu_multicycle
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       control,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] out_hi,
    output logic             zero,
    output logic             carry,
    output logic             ovf,
    output logic             err
);

    alu_state_e       state_q;
    logic [3:0]       op_q;
    logic [WIDTH-1:0] out_q;
    logic [WIDTH-1:0] out_hi_q;
    alu_flags_t       flags_q;

    logic [WIDTH-1:0] sc_lo;
    logic [WIDTH-1:0] sc_hi;
    alu_flags_t       sc_flags;
    logic             sc_seq;
    logic [WIDTH:0]   add_sum;
    logic [WIDTH:0]   sub_sum;

    logic             eng_start;
    logic             eng_done;
    logic [WIDTH-1:0] eng_lo;
    logic [WIDTH-1:0] eng_hi;
    logic [WIDTH-1:0] fin_lo;
    logic [WIDTH-1:0] fin_hi;
    alu_flags_t       fin_flags;

    always_comb begin
        sc_lo    = '0;
        sc_hi    = '0;
        sc_flags = '0;
        sc_seq   = op_is_seq(control);
        add_sum  = {1'b0, in1} + {1'b0, in2};
        sub_sum  = {1'b0, in1} + {1'b0, ~in2} + (WIDTH+1)'(1);
        case (control)
            ALU_AND: sc_lo = in1 & in2;
            ALU_OR:  sc_lo = in1 | in2;
            ALU_XOR: sc_lo = in1 ^ in2;
            ALU_ADD: begin
                sc_lo          = add_sum[WIDTH-1:0];
                sc_flags.carry = add_sum[WIDTH];
                sc_flags.ovf   = (in1[WIDTH-1] == in2[WIDTH-1]) &&
                                 (add_sum[WIDTH-1] != in1[WIDTH-1]);
            end
            ALU_SUB: begin
                // carry reports borrow, i.e. the inverted carry-out of A + ~B + 1
                sc_lo          = sub_sum[WIDTH-1:0];
                sc_flags.carry = ~sub_sum[WIDTH];
                sc_flags.ovf   = (in1[WIDTH-1] != in2[WIDTH-1]) &&
                                 (sub_sum[WIDTH-1] != in1[WIDTH-1]);
            end
            ALU_SLT: sc_lo = {{(WIDTH-1){1'b0}}, ($signed(in1) < $signed(in2))};
            ALU_MULT: ;
`ifdef ALU_DIV_EN
            ALU_DIV, ALU_REM: begin
                if (in2 == '0) begin
                    sc_seq       = 1'b0;
                    sc_lo        = '1;
                    sc_hi        = in1;
                    sc_flags.err = 1'b1;
                end
            end
`endif
            default: sc_flags.err = 1'b1;
        endcase
        sc_flags.zero = (sc_lo == '0);
    end

    assign eng_start = (state_q == IDLE) && in_valid && sc_seq;

    alu_seq_muldiv #(
        .WIDTH (WIDTH)
    ) u_muldiv (
        .clk     (clk),
        .rst     (rst),
        .start_i (eng_start),
        .div_i   (control[3]),
        .a_i     (in1),
        .b_i     (in2),
        .done_o  (eng_done),
        .lo_o    (eng_lo),
        .hi_o    (eng_hi)
    );

    always_comb begin
        fin_lo         = eng_lo;
        fin_hi         = eng_hi;
        fin_flags      = '0;
        fin_flags.zero = (eng_lo == '0);
        fin_flags.ovf  = (op_q == ALU_MULT) && (eng_hi != '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            op_q     <= '0;
            out_q    <= '0;
            out_hi_q <= '0;
            flags_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        op_q <= control;
                        if (sc_seq) begin
                            state_q <= BUSY;
                        end else begin
                            state_q  <= DONE;
                            out_q    <= sc_lo;
                            out_hi_q <= sc_hi;
                            flags_q  <= sc_flags;
                        end
                    end
                end
                BUSY: begin
                    if (eng_done) begin
                        state_q  <= DONE;
                        out_q    <= fin_lo;
                        out_hi_q <= fin_hi;
                        flags_q  <= fin_flags;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out       = out_q;
    assign out_hi    = out_hi_q;
    assign zero      = flags_q.zero;
    assign carry     = flags_q.carry;
    assign ovf       = flags_q.ovf;
    assign err       = flags_q.err;

endmodule

// File: tb/tb_alu_multicycle.sv
// Scoreboard bench for alu_multicycle (WIDTH=32); expectations track ALU_DIV_EN.
module tb_alu_multicycle;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   control;
    logic [W-1:0] in1;
    logic [W-1:0] in2;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out;
    logic [W-1:0] out_hi;
    logic         zero;
    logic         carry;
    logic         ovf;
    logic         err;

    always #5 clk = ~clk;

    alu_multicycle #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .control   (control),
        .in1       (in1),
        .in2       (in2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .out_hi    (out_hi),
        .zero      (zero),
        .carry     (carry),
        .ovf       (ovf),
        .err       (err)
    );

    typedef struct packed {
        logic [31:0] lo;
        logic [31:0] hi;
        logic [3:0]  fl;   // {zero, carry, ovf, err}
        logic [7:0]  lat;
    } exp_t;

    exp_t sb_q[$];
    int   pass_cnt  = 0;
    int   total_cnt = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        total_cnt++;
        if (got === want) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    endtask

    function automatic exp_t model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        logic [63:0] p;
        logic [31:0] t;
        longint      s;
        e     = '0;
        e.lat = 8'd1;
        case (c)
            4'h0: e.lo = a & b;
            4'h1: e.lo = a | b;
            4'h5: e.lo = a ^ b;
            4'h2: begin
                t       = a + b;
                e.lo    = t;
                e.fl[2] = (t < a);
                s       = longint'($signed(a)) + longint'($signed(b));
                e.fl[1] = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'h3: begin
                e.lo    = a - b;
                e.fl[2] = (a < b);
                s       = longint'($signed(a)) - longint'($signed(b));
                e.fl[1] = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'h4: e.lo = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'h7: begin
                p       = {32'd0, a} * {32'd0, b};
                e.lo    = p[31:0];
                e.hi    = p[63:32];
                e.fl[1] = (p[63:32] != 32'd0);
                e.lat   = 8'd33;
            end
            4'h8, 4'h9: begin
`ifdef ALU_DIV_EN
                if (b == 32'd0) begin
                    e.lo    = 32'hFFFF_FFFF;
                    e.hi    = a;
                    e.fl[0] = 1'b1;
                end else begin
                    e.lo  = a / b;
                    e.hi  = a % b;
                    e.lat = 8'd33;
                end
`else
                e.fl[0] = 1'b1;
`endif
            end
            default: e.fl[0] = 1'b1;
        endcase
        e.fl[3] = (e.lo == 32'd0);
        return e;
    endfunction

    // Drive one op, wait for acceptance, then scramble inputs to prove they are sampled once.
    task automatic send(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        int n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) check("accept_timeout", in_ready, 1);
        in_valid = 1'b1;
        control  = c;
        in1      = a;
        in2      = b;
        sb_q.push_back(model(c, a, b));
        @(posedge clk); #1;
        in_valid = 1'b0;
        control  = 4'($urandom);
        in1      = $urandom;
        in2      = $urandom;
    endtask

    // Called right after send(); optionally stalls `hold` cycles in DONE with a competing request.
    task automatic receive(input string tag, input int hold);
        int   cyc = 1;
        exp_t e;
        while (!out_valid && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        e = sb_q.pop_front();
        if (!out_valid) begin
            check({tag, "_out_valid_timeout"}, out_valid, 1);
            return;
        end
        check({tag, "_latency"}, cyc, e.lat);
        check({tag, "_out"},     out, e.lo);
        check({tag, "_out_hi"},  out_hi, e.hi);
        check({tag, "_flags"},   {zero, carry, ovf, err}, e.fl);
        if (hold > 0) begin
            in_valid = 1'b1;
            control  = 4'h2;
            in1      = $urandom;
            in2      = $urandom;
            for (int i = 0; i < hold; i++) begin
                @(posedge clk); #1;
                check({tag, "_hold_in_ready"}, in_ready, 0);
                check({tag, "_hold_valid"},    out_valid, 1);
                check({tag, "_hold_out"},      {out, out_hi}, {e.lo, e.hi});
                check({tag, "_hold_flags"},    {zero, carry, ovf, err}, e.fl);
            end
            in_valid = 1'b0;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, "_handoff_valid"}, out_valid, 0);
        check({tag, "_handoff_ready"}, in_ready, 1);
    endtask

    task automatic run_op(input string tag, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        send(c, a, b);
        receive(tag, 0);
    endtask

    logic [3:0] ops [12] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h7, 4'h8, 4'h9, 4'h6, 4'hF, 4'h7};

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        control   = 4'h0;
        in1       = '0;
        in2       = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("reset_in_ready",  in_ready, 1);
        check("reset_out_valid", out_valid, 0);
        check("reset_out",       {out, out_hi}, 64'd0);
        check("reset_flags",     {zero, carry, ovf, err}, 4'b0000);

        run_op("add_ovf",  4'h2, 32'h7FFF_FFFF, 32'h1);
        run_op("sub_zero", 4'h3, 32'd5, 32'd5);
        send(4'h7, 32'hFFFF_FFFF, 32'd2);
        receive("mult_stall", 10);
        run_op("illegal_f", 4'hF, 32'h1234_5678, 32'h9ABC_DEF0);
        run_op("illegal_6", 4'h6, 32'h1, 32'h2);
        run_op("slt_neg",   4'h4, 32'hFFFF_FFFF, 32'd1);
        run_op("slt_pos",   4'h4, 32'd1, 32'hFFFF_FFFF);
        run_op("div",       4'h8, 32'd100, 32'd7);
        run_op("div_zero",  4'h8, 32'd55, 32'd0);
        run_op("rem",       4'h9, 32'd100, 32'd7);
        run_op("and",       4'h0, 32'hF0F0_1234, 32'hFF00_FF00);
        run_op("sub_borrow", 4'h3, 32'd3, 32'd9);

        // Reset in the middle of a multiply discards it.
        send(4'h7, 32'hDEAD_BEEF, 32'h1234_5678);
        void'(sb_q.pop_back());
        repeat (9) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst_in_ready",  in_ready, 1);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_out",       {out, out_hi}, 64'd0);
        check("midrst_flags",     {zero, carry, ovf, err}, 4'b0000);
        repeat (40) begin
            @(posedge clk); #1;
        end
        check("midrst_stays_idle", out_valid, 0);
        run_op("add_after_rst", 4'h2, 32'd2, 32'd3);

        for (int i = 0; i < 24; i++) begin
            logic [31:0] a;
            logic [31:0] b;
            a = $urandom;
            b = (i % 4 == 0) ? 32'($urandom_range(0, 3)) : $urandom;
            run_op("rand", ops[$urandom_range(0, 11)], a, b);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
